// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit 1, DATA_W data bits LSB first, stop bit 0,
// with a small FIFO of received frames and error/overflow reporting.
module serial_frame_rx #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              frame_err,
  output logic              overflow
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, SHIFT, STOP} state_t;

  state_t            r_state;
  logic [IDX_W-1:0]  r_bitIdx;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [CNT_W-1:0]  r_count;
  logic              r_frameErr;
  logic              r_overflow;

  logic w_pop;
  logic w_full;
  logic w_push;
  logic w_drop;

  assign w_pop  = (r_count != '0) && dout_ready;
  assign w_full = (r_count == FULL_CNT);
  // A full buffer can still accept a frame when the consumer frees a slot on the same edge.
  assign w_push = (r_state == STOP) && !din && (!w_full || w_pop);
  assign w_drop = (r_state == STOP) && !din && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_bitIdx   <= '0;
      r_shift    <= '0;
      r_frameErr <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_frameErr <= 1'b0;
      case (r_state)
        IDLE: begin
          r_bitIdx <= '0;
          if (din) r_state <= SHIFT;
        end
        SHIFT: begin
          r_shift  <= {din, r_shift[DATA_W-1:1]};
          r_bitIdx <= r_bitIdx + IDX_W'(1);
          if (r_bitIdx == LAST_IDX) r_state <= STOP;
        end
        STOP: begin
          r_state <= IDLE;
          if (din) r_frameErr <= 1'b1;
          if (w_drop) r_overflow <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wrPtr] <= r_shift;
        r_wrPtr <= (r_wrPtr == LAST_PTR) ? '0 : r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= (r_rdPtr == LAST_PTR) ? '0 : r_rdPtr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout       = r_mem[r_rdPtr];
  assign dout_valid = (r_count != '0);
  assign frame_err  = r_frameErr;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: reset/idle, single frame, bad stop,
// backpressure with overflow, pop on the full edge, and reset mid-frame.
module tb_serial_frame_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       din;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       frame_err;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  serial_frame_rx #(.DATA_W(8), .DEPTH(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
  task automatic applyStimulus(input logic b);
    @(negedge clk);
    din = b;
    @(posedge clk);
    #1;
  endtask

  task automatic sendStartAndData(input logic [7:0] data);
    applyStimulus(1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(data[i]);
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b1;
    din = 1'b0;
    dout_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int badEdges;
    @(negedge clk);
    reset = 1'b1;
    din = 1'b0;
    dout_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (dout_valid !== 1'b0 || frame_err !== 1'b0 || overflow !== 1'b0 || dout !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_state: valid=%b err=%b ovf=%b dout=%h, required 0 0 0 00",
               dout_valid, frame_err, overflow, dout);
    end
    @(negedge clk);
    reset = 1'b0;
    badEdges = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0);
      if (dout_valid !== 1'b0 || frame_err !== 1'b0 || overflow !== 1'b0) badEdges++;
    end
    checks++;
    if (badEdges != 0) begin
      errors++;
      $display("[TB] FAIL idle_outputs: %0d edges with a flag set, required 0", badEdges);
    end
  endtask

  task automatic test_single_frame();
    int earlyValid;
    dout_ready = 1'b1;
    earlyValid = 0;
    applyStimulus(1'b1);
    if (dout_valid !== 1'b0) earlyValid++;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(8'hA5 >> i);
      if (dout_valid !== 1'b0) earlyValid++;
    end
    checks++;
    if (earlyValid != 0) begin
      errors++;
      $display("[TB] FAIL single_early_valid: %0d early valid edges, required 0", earlyValid);
    end
    applyStimulus(1'b0);
    checks++;
    if (dout_valid !== 1'b1 || dout !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL single_data: valid=%b dout=%h, required 1 a5", dout_valid, dout);
    end
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_err: frame_err=%b, required 0", frame_err);
    end
    applyStimulus(1'b0);
    checks++;
    if (dout_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_one_cycle: valid=%b, required 0", dout_valid);
    end
  endtask

  task automatic test_bad_stop();
    dout_ready = 1'b0;
    sendStartAndData(8'h3C);
    applyStimulus(1'b1);
    checks++;
    if (frame_err !== 1'b1 || dout_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bad_stop_err: err=%b valid=%b, required 1 0", frame_err, dout_valid);
    end
    applyStimulus(1'b0);
    checks++;
    if (frame_err !== 1'b0 || dout_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bad_stop_pulse: err=%b valid=%b, required 0 0", frame_err, dout_valid);
    end
  endtask

  task automatic test_overflow();
    applyReset();
    dout_ready = 1'b0;
    sendStartAndData(8'h11);
    applyStimulus(1'b0);
    checks++;
    if (dout_valid !== 1'b1 || dout !== 8'h11 || overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovf_first: valid=%b dout=%h ovf=%b, required 1 11 0", dout_valid, dout, overflow);
    end
    sendStartAndData(8'h22);
    applyStimulus(1'b0);
    checks++;
    if (overflow !== 1'b0 || dout !== 8'h11) begin
      errors++;
      $display("[TB] FAIL ovf_second: ovf=%b dout=%h, required 0 11", overflow, dout);
    end
    sendStartAndData(8'h33);
    applyStimulus(1'b0);
    checks++;
    if (overflow !== 1'b1 || dout !== 8'h11) begin
      errors++;
      $display("[TB] FAIL ovf_third: ovf=%b dout=%h, required 1 11", overflow, dout);
    end
    @(negedge clk);
    dout_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (dout_valid !== 1'b1 || dout !== 8'h22) begin
      errors++;
      $display("[TB] FAIL ovf_read2: valid=%b dout=%h, required 1 22", dout_valid, dout);
    end
    @(posedge clk);
    #1;
    checks++;
    if (dout_valid !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ovf_drain: valid=%b ovf=%b, required 0 1", dout_valid, overflow);
    end
    @(negedge clk);
    dout_ready = 1'b0;
  endtask

  task automatic test_pop_full();
    applyReset();
    sendStartAndData(8'h11);
    applyStimulus(1'b0);
    sendStartAndData(8'h22);
    applyStimulus(1'b0);
    sendStartAndData(8'h44);
    @(negedge clk);
    din = 1'b0;
    dout_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (overflow !== 1'b0 || dout_valid !== 1'b1 || dout !== 8'h22) begin
      errors++;
      $display("[TB] FAIL popfull_edge: ovf=%b valid=%b dout=%h, required 0 1 22", overflow, dout_valid, dout);
    end
    @(posedge clk);
    #1;
    checks++;
    if (dout_valid !== 1'b1 || dout !== 8'h44) begin
      errors++;
      $display("[TB] FAIL popfull_read44: valid=%b dout=%h, required 1 44", dout_valid, dout);
    end
    @(posedge clk);
    #1;
    checks++;
    if (dout_valid !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL popfull_drain: valid=%b ovf=%b, required 0 0", dout_valid, overflow);
    end
    @(negedge clk);
    dout_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    int badEdges;
    applyReset();
    dout_ready = 1'b1;
    applyStimulus(1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1);
    @(negedge clk);
    reset = 1'b1;
    din = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (dout_valid !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_state: valid=%b err=%b, required 0 0", dout_valid, frame_err);
    end
    badEdges = 0;
    applyStimulus(1'b1);
    if (dout_valid !== 1'b0 || frame_err !== 1'b0) badEdges++;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(8'h5A >> i);
      if (dout_valid !== 1'b0 || frame_err !== 1'b0) badEdges++;
    end
    checks++;
    if (badEdges != 0) begin
      errors++;
      $display("[TB] FAIL midreset_quiet: %0d bad edges, required 0", badEdges);
    end
    applyStimulus(1'b0);
    checks++;
    if (dout_valid !== 1'b1 || dout !== 8'h5A || frame_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_data: valid=%b dout=%h err=%b, required 1 5a 0", dout_valid, dout, frame_err);
    end
    badEdges = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0);
      if (dout_valid !== 1'b0 || frame_err !== 1'b0) badEdges++;
    end
    checks++;
    if (badEdges != 0) begin
      errors++;
      $display("[TB] FAIL midreset_after: %0d bad edges, required 0", badEdges);
    end
  endtask

  initial begin
    reset = 1'b1;
    din = 1'b0;
    dout_ready = 1'b0;
    test_reset();
    test_single_frame();
    test_bad_stop();
    test_overflow();
    test_pop_full();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
